// File: rtl/ifft_feeder_pkg.sv
// Shared types and constants for the IFFT feeder: FSM encoding, config word,
// saturation limits and the FIFO entry layout.
package ifft_feeder_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam logic [7:0]  IFFT_CFG_WORD = 8'h00;
    localparam int          SAT_MAX    = 32767;
    localparam int          SAT_MIN    = -32768;

    typedef enum logic [1:0] {
        ST_CFG      = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    typedef struct packed {
        logic                last;
        logic [SAMPLE_W-1:0] im;
        logic [SAMPLE_W-1:0] re;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Output data reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array is not reset; emptiness gates the read data instead.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifft_feeder.sv
// Scales 33-bit spectral products to Q15, frames them with bin indices/tlast
// and streams them to an IFFT core after issuing its config word.
module ifft_feeder
    import ifft_feeder_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned SHIFT      = 15,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               s_prod_tvalid,
    input  logic signed [32:0] s_prod_re,
    input  logic signed [32:0] s_prod_im,
    output logic               s_prod_tready,
    input  logic               frame_start,
    output logic [31:0]        m_axis_data_tdata,
    output logic               m_axis_data_tvalid,
    input  logic               m_axis_data_tready,
    output logic               m_axis_data_tlast,
    output logic [7:0]         m_axis_config_tdata,
    output logic               m_axis_config_tvalid,
    input  logic               m_axis_config_tready,
    input  logic               clr,
    output logic               sat_flag,
    output logic               sync_err
);

    localparam int unsigned IDX_W   = $clog2(FRAME_LEN);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    logic              rst_meta;
    logic              rst_n_s;
    state_e            state;
    state_e            state_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic              accept;
    logic              write_c;
    logic              clip_re;
    logic              clip_im;
    logic [15:0]       re_r;
    logic [15:0]       im_r;
    fifo_entry_t       entry_c;
    logic              pipe_vld;
    fifo_entry_t       pipe_q;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_pop;
    logic [ENTRY_W-1:0] fifo_dout;
    fifo_entry_t       out_e;
    logic [OCC_W-1:0]  occ_n;
    logic              tready_n;
    logic              sat_evt;
    logic              sync_evt;

    // Reset asserts immediately, releases two clock edges later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_meta <= 1'b0;
            rst_n_s  <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n_s  <= rst_meta;
        end
    end

    // Round half up, arithmetic shift, clip to signed 16 bits; msb flags a clip.
    function automatic logic [16:0] round_sat(input logic signed [32:0] x);
        logic signed [34:0] t;
        t = 35'(x) + (35'sd1 <<< (SHIFT - 1));
        t = t >>> SHIFT;
        if (t > 35'(SAT_MAX))      return {1'b1, 16'(SAT_MAX)};
        else if (t < 35'(SAT_MIN)) return {1'b1, 16'(SAT_MIN)};
        else                       return {1'b0, t[15:0]};
    endfunction

    assign {clip_re, re_r} = round_sat(s_prod_re);
    assign {clip_im, im_r} = round_sat(s_prod_im);
    assign accept          = s_prod_tvalid && s_prod_tready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        write_c = 1'b0;
        unique case (state)
            ST_CFG: begin
                if (m_axis_config_tvalid && m_axis_config_tready) state_n = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (accept && frame_start) begin
                    write_c = 1'b1;
                    state_n = ST_RUN;
                    idx_n   = IDX_W'(1);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    write_c = 1'b1;
                    idx_n   = idx + IDX_W'(1);
                end
            end
            default: state_n = ST_CFG;
        endcase
    end

    always_comb begin
        entry_c      = '0;
        entry_c.last = (state == ST_RUN) && (idx == IDX_W'(FRAME_LEN - 1));
        entry_c.re   = re_r;
        entry_c.im   = im_r;
    end

    assign fifo_pop = m_axis_data_tvalid && m_axis_data_tready;
    assign sat_evt  = write_c && (clip_re || clip_im);
    assign sync_evt = accept && frame_start && (state == ST_RUN) && (idx != '0);

    // Occupancy (FIFO + pipeline) as it will stand after this edge.
    assign occ_n = OCC_W'(fifo_count) + OCC_W'(pipe_vld) - OCC_W'(fifo_pop) + OCC_W'(write_c);

    always_comb begin
        tready_n = 1'b0;
        unique case (state_n)
            ST_WAIT_SOF: tready_n = 1'b1;
            ST_RUN:      tready_n = (occ_n <= OCC_W'(FIFO_DEPTH - 2));
            default:     tready_n = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state                <= ST_CFG;
            idx                  <= '0;
            pipe_vld             <= 1'b0;
            pipe_q               <= '0;
            m_axis_config_tvalid <= 1'b0;
            s_prod_tready        <= 1'b0;
            sat_flag             <= 1'b0;
            sync_err             <= 1'b0;
        end else begin
            state                <= state_n;
            idx                  <= idx_n;
            pipe_vld             <= write_c;
            pipe_q               <= entry_c;
            m_axis_config_tvalid <= (state_n == ST_CFG);
            s_prod_tready        <= tready_n;
            sat_flag             <= sat_evt  || (sat_flag && !clr);
            sync_err             <= sync_evt || (sync_err && !clr);
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (rst_n_s),
        .push  (pipe_vld),
        .din   (pipe_q),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign out_e               = fifo_entry_t'(fifo_dout);
    assign m_axis_data_tdata   = {out_e.im, out_e.re};
    assign m_axis_data_tlast   = out_e.last;
    assign m_axis_data_tvalid  = (fifo_count != '0);
    assign m_axis_config_tdata = IFFT_CFG_WORD;

endmodule
